shared_adder_arb: RTL and testbench

SHARED_ADDER_ARB -- requirements
Module: shared_adder_arb

---
 rtl/shared_adder_arb.sv | 132 +++++++++++++
 tb/tb_shared_adder_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_arb.sv
// Shared adder with a two-requester round-robin arbiter and a one-entry result register.
// Latency: 1 cycle from accept to out_valid. Optional grant counters via SHARED_ADDER_ARB_STATS_EN.
// Backpressure: in_ready stays low while a result is held and out_ready is low.
module shared_adder_arb #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           in_valid,
  output logic [1:0]           in_ready,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout,
  output logic                 out_id
`ifdef SHARED_ADDER_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] gnt_cnt0,
  output logic [CNT_WIDTH-1:0] gnt_cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;

  logic             can_accept;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   add_res;

  // Arbitration, operand select and the single shared adder.
  always_comb begin
    // rst_n gates acceptance so in_ready is quiet throughout reset.
    can_accept = rst_n && ((state_q == EMPTY) || out_ready);
    if (in_valid == 2'b11) begin
      grant_id = ~last_q;
    end else begin
      grant_id = in_valid[1] & ~in_valid[0];
    end
    accept   = can_accept && (in_valid != 2'b00);
    in_ready = 2'b00;
    if (accept) begin
      in_ready = grant_id ? 2'b10 : 2'b01;
    end
    op_a    = grant_id ? a1 : a0;
    op_b    = grant_id ? b1 : b0;
    add_res = {1'b0, op_a} + {1'b0, op_b};
  end

  // Output FSM next state, result register loads and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    if (accept) begin
      state_d = FULL;
      last_d  = grant_id;
      sum_d   = add_res[WIDTH-1:0];
      cout_d  = add_res[WIDTH];
      id_d    = grant_id;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and result registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_id    = id_q;

`ifdef SHARED_ADDER_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  // Saturating per-requester grant counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !grant_id && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_WIDTH'(1);
    end
    if (accept && grant_id && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shared_adder_arb.sv
module tb_shared_adder_arb;

  localparam int WIDTH     = 5;
  localparam int CNT_WIDTH = 8;
  localparam int NVEC      = 14;

  logic             clk;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_id;
`ifdef SHARED_ADDER_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] gnt_cnt0, gnt_cnt1;
`endif

  int errors;
  int checks;

  shared_adder_arb #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_id    (out_id)
`ifdef SHARED_ADDER_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] iv;
    logic [4:0] a0, b0, a1, b1;
    logic       ordy;
    logic [1:0] rdy;
    logic       vld;
    logic [4:0] sum;
    logic       cout;
    logic       id;
  } vec_t;

  vec_t vec [NVEC];

  function automatic vec_t mk(input logic [1:0] iv, input logic [4:0] xa0, xb0, xa1, xb1,
                              input logic ordy, input logic [1:0] rdy, input logic vld,
                              input logic [4:0] sum, input logic cout, input logic id);
    vec_t v;
    v.iv = iv; v.a0 = xa0; v.b0 = xb0; v.a1 = xa1; v.b1 = xb1; v.ordy = ordy;
    v.rdy = rdy; v.vld = vld; v.sum = sum; v.cout = cout; v.id = id;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [4:0] sum,
                           input logic cout, input logic id);
    check({tag, " out_valid"}, 32'(out_valid), 32'(vld));
    check({tag, " out_sum"},   32'(out_sum),   32'(sum));
    check({tag, " out_cout"},  32'(out_cout),  32'(cout));
    check({tag, " out_id"},    32'(out_id),    32'(id));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Vectors applied one per cycle right after reset; pointer starts at 1.
    //           iv     a0     b0     a1     b1   ordy  rdy   vld sum   cout id
    vec[0]  = mk(2'b11, 5'd3,  5'd4,  5'd10, 5'd20, 1'b1, 2'b01, 1, 5'd7,  0, 0);
    vec[1]  = mk(2'b11, 5'd3,  5'd4,  5'd10, 5'd20, 1'b1, 2'b10, 1, 5'd30, 0, 1);
    vec[2]  = mk(2'b11, 5'd3,  5'd4,  5'd10, 5'd20, 1'b1, 2'b01, 1, 5'd7,  0, 0);
    vec[3]  = mk(2'b11, 5'd3,  5'd4,  5'd10, 5'd20, 1'b1, 2'b10, 1, 5'd30, 0, 1);
    vec[4]  = mk(2'b11, 5'd3,  5'd4,  5'd10, 5'd20, 1'b1, 2'b01, 1, 5'd7,  0, 0);
    vec[5]  = mk(2'b11, 5'd3,  5'd4,  5'd10, 5'd20, 1'b1, 2'b10, 1, 5'd30, 0, 1);
    vec[6]  = mk(2'b01, 5'd31, 5'd1,  5'd0,  5'd0,  1'b1, 2'b01, 1, 5'd0,  1, 0);
    vec[7]  = mk(2'b10, 5'd0,  5'd0,  5'd31, 5'd31, 1'b1, 2'b10, 1, 5'd30, 1, 1);
    vec[8]  = mk(2'b00, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 2'b00, 0, 5'd30, 1, 1);
    vec[9]  = mk(2'b01, 5'd16, 5'd15, 5'd0,  5'd0,  1'b1, 2'b01, 1, 5'd31, 0, 0);
    vec[10] = mk(2'b11, 5'd16, 5'd15, 5'd7,  5'd9,  1'b0, 2'b00, 1, 5'd31, 0, 0);
    vec[11] = mk(2'b11, 5'd16, 5'd15, 5'd7,  5'd9,  1'b1, 2'b10, 1, 5'd16, 0, 1);
    vec[12] = mk(2'b00, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 1, 5'd16, 0, 1);
    vec[13] = mk(2'b00, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 2'b00, 0, 5'd16, 0, 1);

    // Reset with both requesters active.
    rst_n = 1'b0; in_valid = 2'b11; out_ready = 1'b1;
    a0 = 5'd3; b0 = 5'd4; a1 = 5'd10; b1 = 5'd20;
    #3;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd0);
    check("reset out_sum",   32'(out_sum),   32'd0);
    tick();
    tick();
    check("reset held in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // Table-driven: single requests, contention, overflow, stall.
    for (int i = 0; i < NVEC; i++) begin
      in_valid = vec[i].iv; a0 = vec[i].a0; b0 = vec[i].b0;
      a1 = vec[i].a1; b1 = vec[i].b1; out_ready = vec[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vec[i].rdy));
      tick();
      check_out($sformatf("vec%0d", i), vec[i].vld, vec[i].sum, vec[i].cout, vec[i].id);
    end

    // Backpressure: load a result, stall 3 cycles with requester 1 waiting.
    in_valid = 2'b01; a0 = 5'd1; b0 = 5'd2; out_ready = 1'b1;
    tick();
    check_out("bp load", 1, 5'd3, 0, 0);
    in_valid = 2'b10; a1 = 5'd5; b1 = 5'd6; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp stall%0d in_ready", c), 32'(in_ready), 32'd0);
      tick();
      check_out($sformatf("bp stall%0d", c), 1, 5'd3, 0, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd2);
    tick();
    check_out("bp release", 1, 5'd11, 0, 1);

    // Reset mid-operation, between clock edges.
    in_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    in_valid = 2'b11;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready",  32'(in_ready),  32'd0);
    check("midrst out_sum",   32'(out_sum),   32'd0);
    tick();
    in_valid = 2'b00;
    rst_n = 1'b1;
    tick();
    tick();
    check("post rst out_valid", 32'(out_valid), 32'd0);
    // Pointer is back to its reset value: requester 0 wins the tie.
    in_valid = 2'b11; a0 = 5'd8; b0 = 5'd8; a1 = 5'd1; b1 = 5'd1;
    #1;
    check("post rst tie in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("post rst tie", 1, 5'd16, 0, 0);

`ifdef SHARED_ADDER_ARB_STATS_EN
    // Counters restart from the mid-operation reset; one accept from 0 so far.
    check("cnt0 after one", 32'(gnt_cnt0), 32'd1);
    in_valid = 2'b01; out_ready = 1'b1;
    for (int k = 0; k < 299; k++) tick();
    check("cnt0 saturated", 32'(gnt_cnt0), 32'd255);
    check("cnt1 zero",      32'(gnt_cnt1), 32'd0);
`endif

    in_valid = 2'b00;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
